icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache. It is the successor to the flat combinational instruction store and sits between the fetch stage and a word-wide backing instruction memory.
- Hits return the instruction combinationally in the same cycle. This keeps the existing single-cycle fetch timing.
- Misses stall fetch while a refill FSM fetches the whole line, one word per beat.
- Adds a whole-cache invalidate (for fence.i / code loading) and a miss counter.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, >= 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, >= 2.
- ADDR_W, 32, byte-address width of pc_i and mem_addr_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  fetch request valid for pc_i.
- pc_i  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- instr_o  out  32  instruction word; valid when hit_o.
- hit_o  out  1  req_i & lookup hit & FSM in IDLE.
- stall_o  out  1  fetch must hold pc_i and retry.
- flush_i  in  1  invalidate all lines (one-cycle pulse).
- mem_req_o  out  1  backing-memory read request.
- mem_addr_o  out  ADDR_W  word-aligned read address.
- mem_rvalid_i  in  1  read data valid; completes the current beat.
- mem_rdata_i  in  32  read data.
- miss_cnt_o  out  32  number of refills started; saturates.

Behaviour:
- Address split:
  - OFF_W = log2(LINE_WORDS), IDX_W = log2(NUM_LINES).
  - word offset = pc_i[OFF_W+1:2]; index = pc_i[IDX_W+OFF_W+1:OFF_W+2].
  - tag = remaining upper bits, TAG_W = ADDR_W-2-OFF_W-IDX_W.
- Storage: valid[NUM_LINES], tag[NUM_LINES][TAG_W] and data[NUM_LINES][LINE_WORDS][32], all flops.
- Lookup is combinational: hit = valid[idx] & (tag[idx]==pc_tag).
  - instr_o = data[idx][off] at all times.
  - hit_o = req_i & hit & state==IDLE.
  - stall_o = (req_i & ~hit) | (state!=IDLE).
- FSM states: IDLE, REFILL, DONE.
  - IDLE: on req_i & ~hit & ~flush_i, latch line base address (pc_i with offset and byte bits zeroed), clear valid[idx], write tag[idx], set beat=0, increment miss_cnt, go to REFILL.
  - REFILL: drive mem_req_o=1 and mem_addr_o=base+4*beat.
    - On mem_rvalid_i, write data[idx][beat]=mem_rdata_i.
    - If beat==LINE_WORDS-1, go to DONE; otherwise beat+1.
    - mem_req_o and mem_addr_o stay stable until mem_rvalid_i. Data may return in the same cycle as the request.
  - DONE: set valid[idx]=1 (unless aborted), go to IDLE. The retried fetch then hits.
- Miss latency, with N = LINE_WORDS and L = memory cycles per beat:
  - stall_o is high for 1 (IDLE detect) + N*L (REFILL) + 1 (DONE) cycles.
  - The hit occurs in the following cycle.
- Flush:
  - In IDLE: all valid bits clear at the next edge. A miss in the same cycle is not started; it is re-detected next cycle.
  - In REFILL: set an abort flag. The in-flight beat completes (protocol is never broken), then the FSM goes directly to IDLE without setting valid.
  - In DONE: valid is not set.
  - Flush does not reset miss_cnt_o.
- Reset (async, rst_ni=0):
  - All valid bits 0, state IDLE, beat 0, abort 0, miss_cnt_o 0, mem_req_o 0.
  - mem_addr_o is 0; hit_o is 0; stall_o equals req_i.
  - Tag and data arrays are not reset.
  - Reset mid-refill abandons the beat. The memory model must tolerate the dropped request.
- mem_addr_o is 0 whenever mem_req_o=0.
- req_i low while the FSM is busy: the refill still completes.
- miss_cnt_o saturates at 32'hFFFF_FFFF.

Decomposition:
- Package icache_pkg:
  - State enum (IDLE/REFILL/DONE).
  - Functions computing OFF_W, IDX_W and TAG_W from the parameters.
- One natural sub-module, icache_refill_fsm: state, beat counter, abort flag and memory handshake, emitting write-enable, beat and line-valid-set strobes.
- Arrays, lookup and miss counter stay in icache_dm.

Test Plan:
- Cold miss: after reset, req_i=1, pc_i=0x0000_0010, memory returns word address<<8, L=1 → stall_o high 6 cycles; mem_addr_o 0x10, 0x14, 0x18, 0x1C; then hit_o=1 with instr_o=0x0000_0400; miss_cnt_o=1.
- Same-line hits: pc_i=0x14, 0x18, 0x1C in consecutive cycles after the refill → hit_o=1 each cycle; instr_o=0x500, 0x600, 0x700; no mem_req_o.
- Conflict eviction: fetch 0x10, then 0x110 (same index, different tag), then 0x10 → three refills; miss_cnt_o=3; final instr_o=0x400.
- Slow memory: L=3 cycles per beat on a cold miss at 0x40 → stall_o high 1+12+1=14 cycles; mem_addr_o holds each address for 3 cycles.
- Flush: pc_i=0x10 resident, pulse flush_i in IDLE → next fetch of 0x10 misses. Then flush_i during beat 1 of a refill of 0x20 → beat 1 completes; FSM returns to IDLE without validating; the retry refills 0x20 again.
- Async reset mid-refill: assert rst_ni=0 during beat 2 → mem_req_o drops immediately; after release, fetch of the same address misses; miss_cnt_o restarts at 1.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int num_lines, input int line_words);
    return addr_w - 2 - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: walks one line word by word over the memory handshake.
//   state  | meaning
//   IDLE   | waiting for a miss
//   REFILL | one beat outstanding per word; abort remembers a flush
//   DONE   | line complete, validate unless flushed
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic              flush_i,
  input  logic              mem_rvalid_i,
  output state_t            state,
  output logic [OFF_W-1:0]  beat,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              wr_en,
  output logic              set_valid
);

  logic              abort;
  logic [ADDR_W-1:0] line_base;
  logic [OFF_W-1:0]  beat_nx;
  logic              last_beat;

  assign beat_nx   = beat + OFF_W'(1);
  assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));
  assign wr_en     = (state == REFILL) && mem_rvalid_i;
  assign set_valid = (state == DONE) && !abort && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      beat       <= '0;
      abort      <= 1'b0;
      line_base  <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          abort <= 1'b0;
          if (start) begin
            line_base  <= start_base;
            beat       <= '0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= start_base;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (flush_i) abort <= 1'b1;
          if (mem_rvalid_i) begin
            // A flush only takes effect once the outstanding beat has been accepted.
            if (abort || flush_i || last_beat) begin
              mem_req_o  <= 1'b0;
              mem_addr_o <= '0;
              abort      <= 1'b0;
              state      <= (abort || flush_i) ? IDLE : DONE;
            end else begin
              beat       <= beat_nx;
              mem_addr_o <= line_base | ADDR_W'({beat_nx, 2'b00});
            end
          end
        end
        DONE: begin
          abort <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational hit path, stalling line refill,
// whole-cache flush and a saturating refill counter.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [31:0]       instr_o,
  output logic              hit_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       miss_cnt_o
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(ADDR_W, NUM_LINES, LINE_WORDS);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  ref_idx;
  logic [ADDR_W-1:0] start_base;
  logic              hit, start, wr_en, set_valid;
  logic [OFF_W-1:0]  beat;
  state_t            state;
  logic              unused_pc;

  assign pc_off     = pc_i[OFF_W+1:2];
  assign pc_idx     = pc_i[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_tag     = pc_i[ADDR_W-1:ADDR_W-TAG_W];
  assign start_base = {pc_i[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign unused_pc  = ^pc_i[1:0];

  assign hit     = valid[pc_idx] && (tags[pc_idx] == pc_tag);
  assign start   = req_i && !hit && !flush_i && (state == IDLE);
  assign instr_o = data[pc_idx][pc_off];
  assign hit_o   = req_i && hit && (state == IDLE);
  assign stall_o = (req_i && !hit) || (state != IDLE);

  icache_refill_fsm #(
    .ADDR_W    (ADDR_W),
    .LINE_WORDS(LINE_WORDS),
    .OFF_W     (OFF_W)
  ) u_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start       (start),
    .start_base  (start_base),
    .flush_i     (flush_i),
    .mem_rvalid_i(mem_rvalid_i),
    .state       (state),
    .beat        (beat),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .wr_en       (wr_en),
    .set_valid   (set_valid)
  );

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (start) begin
      tags[pc_idx] <= pc_tag;
      ref_idx      <= pc_idx;
    end
    if (wr_en) data[ref_idx][beat] <= mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid <= '0;
    end else if (flush_i) begin
      valid <= '0;
    end else begin
      if (start)     valid[pc_idx]  <= 1'b0;
      if (set_valid) valid[ref_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         miss_cnt_o <= '0;
    else if (start && miss_cnt_o != '1)  miss_cnt_o <= miss_cnt_o + 32'd1;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a latency-programmable word memory model.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        hit, stall, flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int lat_cnt = 0;
  logic [31:0] beat_q[$];
  logic [31:0] req_q[$];

  always #5 clk = ~clk;

  icache_dm dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .pc_i(pc), .instr_o(instr),
    .hit_o(hit), .stall_o(stall), .flush_i(flush), .mem_req_o(mem_req),
    .mem_addr_o(mem_addr), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .miss_cnt_o(miss_cnt)
  );

  // Memory: data = word address << 8, rvalid on the lat-th cycle of each request.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (mem_req) begin
      req_q.push_back(mem_addr);
      lat_cnt = lat_cnt + 1;
      if (lat_cnt == lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (mem_addr >> 2) << 8;
        beat_q.push_back(mem_addr);
        lat_cnt = 0;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  // Issue a fetch (at posedge+1), count stall cycles until it hits, check result.
  task automatic fetch_miss(input string name, input logic [31:0] addr,
                            input int exp_stall, input logic [31:0] exp_instr);
    int n = 0;
    req = 1'b1; pc = addr;
    for (int i = 0; i < 200; i++) begin
      sample();
      if (!stall) break;
      n++;
      next_cycle();
    end
    check({name, " stall cycles"}, n, exp_stall);
    check({name, " hit"}, {31'b0, hit}, 32'd1);
    check({name, " instr"}, instr, exp_instr);
    next_cycle();
    req = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        exp_hit;
    logic        exp_stall;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] exp_addrs[$];

  initial begin
    vecs[0] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h500};
    vecs[1] = '{1'b1, 32'h18, 1'b1, 1'b0, 32'h600};
    vecs[2] = '{1'b1, 32'h1C, 1'b1, 1'b0, 32'h700};
    vecs[3] = '{1'b1, 32'h13, 1'b1, 1'b0, 32'h400};
    vecs[4] = '{1'b0, 32'h14, 1'b0, 1'b0, 32'h500};

    // Reset state
    req = 1'b1; pc = 32'h10;
    #3;
    check("rst stall=req(1)", {31'b0, stall}, 32'd1);
    check("rst hit", {31'b0, hit}, 32'd0);
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst miss_cnt", miss_cnt, 32'd0);
    req = 1'b0; #1;
    check("rst stall=req(0)", {31'b0, stall}, 32'd0);
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Cold miss
    beat_q.delete();
    fetch_miss("cold", 32'h10, 6, 32'h400);
    check("cold miss_cnt", miss_cnt, 32'd1);
    check("cold beats", beat_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < beat_q.size(); i++)
      check("cold beat addr", beat_q[i], 32'h10 + 32'(4 * i));

    // Same-line hits from the table
    req_q.delete();
    for (int i = 0; i < 5; i++) begin
      req = vecs[i].req; pc = vecs[i].pc;
      sample();
      check("vec hit", {31'b0, hit}, {31'b0, vecs[i].exp_hit});
      check("vec stall", {31'b0, stall}, {31'b0, vecs[i].exp_stall});
      check("vec instr", instr, vecs[i].exp_instr);
      next_cycle();
    end
    req = 1'b0;
    check("vec no mem_req", req_q.size(), 32'd0);

    // Conflict eviction
    fetch_miss("evict 110", 32'h110, 6, 32'h4400);
    fetch_miss("evict 10", 32'h10, 6, 32'h400);
    check("evict miss_cnt", miss_cnt, 32'd3);

    // Slow memory
    lat = 3;
    req_q.delete();
    fetch_miss("slow", 32'h40, 14, 32'h1000);
    check("slow req cycles", req_q.size(), 32'd12);
    for (int i = 0; i < 12 && i < req_q.size(); i++)
      check("slow addr hold", req_q[i], 32'h40 + 32'(4 * (i / 3)));
    check("slow miss_cnt", miss_cnt, 32'd4);
    lat = 1;

    // Flush in IDLE, then a miss coincident with flush is not started
    flush = 1'b1;
    next_cycle();
    flush = 1'b0; req = 1'b1; pc = 32'h40; flush = 1'b1;
    next_cycle();
    flush = 1'b0; req = 1'b0;
    sample();
    check("flush+miss no mem_req", {31'b0, mem_req}, 32'd0);
    check("flush+miss cnt", miss_cnt, 32'd4);
    next_cycle();
    fetch_miss("post-flush 10", 32'h10, 6, 32'h400);
    check("post-flush cnt", miss_cnt, 32'd5);

    // Flush during beat 1 of refill of 0x20
    beat_q.delete();
    req = 1'b1; pc = 32'h20;
    next_cycle();
    next_cycle();
    check("abort beat1 addr", mem_addr, 32'h24);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    sample();
    check("abort idle mem_req", {31'b0, mem_req}, 32'd0);
    check("abort idle hit", {31'b0, hit}, 32'd0);
    check("abort cnt", miss_cnt, 32'd6);
    next_cycle();
    // The retry was detected in the cycle just sampled; re-issue from there.
    // fetch_miss starts a cycle later, so that cycle's stall has already elapsed.
    fetch_miss("abort retry", 32'h20, 5, 32'h800);
    check("abort retry cnt", miss_cnt, 32'd7);
    exp_addrs = '{32'h20, 32'h24, 32'h20, 32'h24, 32'h28, 32'h2C};
    check("abort beats", beat_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < beat_q.size(); i++)
      check("abort beat addr", beat_q[i], exp_addrs[i]);

    // Async reset during beat 2
    req = 1'b1; pc = 32'h30;
    next_cycle(); next_cycle(); next_cycle();
    check("rstmid beat2 addr", mem_addr, 32'h38);
    rst_n = 1'b0; req = 1'b0;
    #1;
    check("rstmid mem_req", {31'b0, mem_req}, 32'd0);
    check("rstmid mem_addr", mem_addr, 32'd0);
    check("rstmid cnt", miss_cnt, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    fetch_miss("rstmid refetch", 32'h30, 6, 32'hC00);
    check("rstmid cnt restart", miss_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
